// File: rtl/keyboard_voice_tracker_if.sv
// Bundles the scan-byte input and the voice/control outputs of keyboard_voice_tracker.
// The master modport is the stimulus/consumer side, and the slave modport is the tracker itself.
interface keyboard_voice_tracker_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned OCT_W      = 2
);
  logic [7:0]                   code;
  logic                         code_valid;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES*OCT_W-1:0]  voice_octave;
  logic [NUM_VOICES-1:0]        voice_active;
  logic [OCT_W-1:0]             octave;
  logic                         note_on;
  logic                         note_off;
  logic                         load_n;
  logic                         playback;
  logic                         overflow;

  modport master (
    output code, code_valid,
    input  voice_note, voice_octave, voice_active, octave,
    input  note_on, note_off, load_n, playback, overflow
  );

  modport slave (
    input  code, code_valid,
    output voice_note, voice_octave, voice_active, octave,
    output note_on, note_off, load_n, playback, overflow
  );
endinterface

// File: rtl/keyboard_voice_tracker.sv
// PS/2 scan-byte parser that tracks held note keys in polyphonic voice slots, the octave,
// and the recorder pulses. The optional macro KEYBOARD_OCTAVE_STEP_EN enables Z/X octave stepping.
module keyboard_voice_tracker #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned NOTE_W         = 4,
  parameter int unsigned OCT_W          = 2,
  parameter int unsigned DEFAULT_OCTAVE = 1
) (
  input logic                     i_clock,
  input logic                     i_resetn,
  keyboard_voice_tracker_if.slave io_kb
);

  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e                              r_state, w_state_next;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]   r_note, w_note_next;
  logic [NUM_VOICES-1:0][OCT_W-1:0]    r_oct, w_oct_next;
  logic [NUM_VOICES-1:0]               r_active, w_active_next;
  logic [OCT_W-1:0]                    r_octave, w_octave_next;
  logic                                r_note_on, w_note_on_next;
  logic                                r_note_off, w_note_off_next;
  logic                                r_load_n, w_load_n_next;
  logic                                r_playback, w_playback_next;
  logic                                r_overflow, w_overflow_next;

  logic [NOTE_W-1:0] w_key_note;
  logic              w_match_found, w_free_found;
  logic [IdxW-1:0]   w_match_idx, w_free_idx;

  function automatic logic [NOTE_W-1:0] note_of(input logic [7:0] c);
    case (c)
      8'h1C:   note_of = NOTE_W'(1);
      8'h15:   note_of = NOTE_W'(2);
      8'h1B:   note_of = NOTE_W'(3);
      8'h23:   note_of = NOTE_W'(4);
      8'h24:   note_of = NOTE_W'(5);
      8'h2B:   note_of = NOTE_W'(6);
      8'h2D:   note_of = NOTE_W'(7);
      8'h34:   note_of = NOTE_W'(8);
      8'h33:   note_of = NOTE_W'(9);
      8'h35:   note_of = NOTE_W'(10);
      8'h3B:   note_of = NOTE_W'(11);
      8'h3C:   note_of = NOTE_W'(12);
      default: note_of = '0;
    endcase
  endfunction

  // Descending scan leaves the lowest matching/free slot index.
  always_comb begin
    w_key_note    = note_of(io_kb.code);
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_note[i] == w_key_note)) begin
        w_match_found = 1'b1;
        w_match_idx   = IdxW'(i);
      end
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_note_next     = r_note;
    w_oct_next      = r_oct;
    w_active_next   = r_active;
    w_octave_next   = r_octave;
    w_note_on_next  = 1'b0;
    w_note_off_next = 1'b0;
    w_load_n_next   = 1'b1;
    w_playback_next = 1'b0;
    w_overflow_next = r_overflow;

    if (io_kb.code_valid) begin
      unique case (r_state)
        StIdle: begin
          if (io_kb.code == 8'hF0) begin
            w_state_next = StBrk;
          end else if (io_kb.code == 8'hE0) begin
            w_state_next = StExt;
          end else if (w_key_note != '0) begin
            // A note already held is a typematic repeat and changes nothing.
            if (!w_match_found) begin
              if (w_free_found) begin
                w_note_next[w_free_idx]   = w_key_note;
                w_oct_next[w_free_idx]    = r_octave;
                w_active_next[w_free_idx] = 1'b1;
                w_note_on_next            = 1'b1;
              end else begin
                w_overflow_next = 1'b1;
              end
            end
          end else begin
            case (io_kb.code)
              8'h16: w_octave_next = OCT_W'(0);
              8'h1E: w_octave_next = OCT_W'(1);
              8'h26: w_octave_next = OCT_W'(2);
              8'h25: w_octave_next = OCT_W'(3);
              8'h29: w_load_n_next = 1'b0;
              8'h5A: w_playback_next = 1'b1;
`ifdef KEYBOARD_OCTAVE_STEP_EN
              8'h1A: if (r_octave != '0) w_octave_next = r_octave - OCT_W'(1);
              8'h22: if (r_octave != '1) w_octave_next = r_octave + OCT_W'(1);
`endif
              default: ;
            endcase
          end
        end
        StBrk: begin
          w_state_next = StIdle;
          if ((w_key_note != '0) && w_match_found) begin
            w_note_next[w_match_idx]   = '0;
            w_oct_next[w_match_idx]    = '0;
            w_active_next[w_match_idx] = 1'b0;
            w_note_off_next            = 1'b1;
          end
        end
        StExt: begin
          w_state_next = (io_kb.code == 8'hF0) ? StExtBrk : StIdle;
        end
        StExtBrk: begin
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= StIdle;
      r_note     <= '0;
      r_oct      <= '0;
      r_active   <= '0;
      r_octave   <= OCT_W'(DEFAULT_OCTAVE);
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_load_n   <= 1'b1;
      r_playback <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_note     <= w_note_next;
      r_oct      <= w_oct_next;
      r_active   <= w_active_next;
      r_octave   <= w_octave_next;
      r_note_on  <= w_note_on_next;
      r_note_off <= w_note_off_next;
      r_load_n   <= w_load_n_next;
      r_playback <= w_playback_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign io_kb.voice_note   = r_note;
  assign io_kb.voice_octave = r_oct;
  assign io_kb.voice_active = r_active;
  assign io_kb.octave       = r_octave;
  assign io_kb.note_on      = r_note_on;
  assign io_kb.note_off     = r_note_off;
  assign io_kb.load_n       = r_load_n;
  assign io_kb.playback     = r_playback;
  assign io_kb.overflow     = r_overflow;

endmodule

// File: tb/tb_keyboard_voice_tracker.sv
// Directed self-checking bench for keyboard_voice_tracker (default parameters).
// Inputs are driven after the falling edge, and outputs are sampled on the next falling edge.
module tb_keyboard_voice_tracker;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  keyboard_voice_tracker_if #(.NUM_VOICES(4), .NOTE_W(4), .OCT_W(2)) kb ();

  keyboard_voice_tracker #(
    .NUM_VOICES    (4),
    .NOTE_W        (4),
    .OCT_W         (2),
    .DEFAULT_OCTAVE(1)
  ) u_dut (
    .i_clock (clk),
    .i_resetn(rst_n),
    .io_kb   (kb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One code_valid cycle, and effects are visible at the returning falling edge.
  task automatic send(input logic [7:0] c);
    @(negedge clk);
    kb.code       = c;
    kb.code_valid = 1'b1;
    @(negedge clk);
    kb.code_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    kb.code       = 8'h00;
    kb.code_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Reset state
    check_eq("rst_active", 32'(kb.voice_active), 32'h0);
    check_eq("rst_note", 32'(kb.voice_note), 32'h0);
    check_eq("rst_voct", 32'(kb.voice_octave), 32'h0);
    check_eq("rst_octave", 32'(kb.octave), 32'h1);
    check_eq("rst_load_n", 32'(kb.load_n), 32'h1);
    check_eq("rst_play", 32'(kb.playback), 32'h0);
    check_eq("rst_ovf", 32'(kb.overflow), 32'h0);
    check_eq("rst_on", 32'(kb.note_on), 32'h0);

    // Single make / break
    send(8'h1C);
    check_eq("mk_on", 32'(kb.note_on), 32'h1);
    check_eq("mk_active", 32'(kb.voice_active), 32'h1);
    check_eq("mk_note", 32'(kb.voice_note), 32'h0001);
    check_eq("mk_voct", 32'(kb.voice_octave), 32'h01);
    idle();
    check_eq("mk_on_pulse", 32'(kb.note_on), 32'h0);
    send(8'hF0);
    check_eq("f0_no_off", 32'(kb.note_off), 32'h0);
    check_eq("f0_active", 32'(kb.voice_active), 32'h1);
    send(8'h1C);
    check_eq("brk_off", 32'(kb.note_off), 32'h1);
    check_eq("brk_active", 32'(kb.voice_active), 32'h0);
    check_eq("brk_note", 32'(kb.voice_note), 32'h0);
    check_eq("brk_voct", 32'(kb.voice_octave), 32'h0);
    idle();
    check_eq("brk_off_pulse", 32'(kb.note_off), 32'h0);

    // Typematic repeat, then octave capture per slot
    send(8'h1C);
    check_eq("rep1_on", 32'(kb.note_on), 32'h1);
    send(8'h1C);
    check_eq("rep2_on", 32'(kb.note_on), 32'h0);
    send(8'h1C);
    check_eq("rep3_on", 32'(kb.note_on), 32'h0);
    check_eq("rep_active", 32'(kb.voice_active), 32'h1);
    send(8'h26);
    check_eq("oct2", 32'(kb.octave), 32'h2);
    send(8'hF0);
    send(8'h26);
    check_eq("oct_brk", 32'(kb.octave), 32'h2);
    send(8'h23);
    check_eq("s1_active", 32'(kb.voice_active), 32'h3);
    check_eq("s1_note", 32'(kb.voice_note), 32'h0041);
    check_eq("s1_voct", 32'(kb.voice_octave), 32'h09);
    // Break matches on note even though the octave has changed since the press
    send(8'hF0);
    send(8'h1C);
    check_eq("brk_oct_chg", 32'(kb.voice_active), 32'h2);
    send(8'hF0);
    send(8'h1C);
    check_eq("brk_unheld", 32'(kb.note_off), 32'h0);
    do_reset();

    // Fill all slots, overflow, free one, refill
    send(8'h1C);
    send(8'h15);
    send(8'h1B);
    send(8'h23);
    check_eq("full_note", 32'(kb.voice_note), 32'h4321);
    check_eq("full_active", 32'(kb.voice_active), 32'hF);
    send(8'h24);
    check_eq("ovf_on", 32'(kb.note_on), 32'h0);
    check_eq("ovf_flag", 32'(kb.overflow), 32'h1);
    check_eq("ovf_note", 32'(kb.voice_note), 32'h4321);
    send(8'hF0);
    send(8'h15);
    check_eq("free_off", 32'(kb.note_off), 32'h1);
    check_eq("free_active", 32'(kb.voice_active), 32'hD);
    check_eq("free_note", 32'(kb.voice_note), 32'h4301);
    send(8'h24);
    check_eq("refill_on", 32'(kb.note_on), 32'h1);
    check_eq("refill_note", 32'(kb.voice_note), 32'h4351);
    check_eq("ovf_sticky", 32'(kb.overflow), 32'h1);

    // Asynchronous reset mid-sequence after F0
    send(8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_active", 32'(kb.voice_active), 32'h0);
    check_eq("arst_note", 32'(kb.voice_note), 32'h0);
    check_eq("arst_ovf", 32'(kb.overflow), 32'h0);
    check_eq("arst_octave", 32'(kb.octave), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h1C);
    check_eq("arst_make_on", 32'(kb.note_on), 32'h1);
    check_eq("arst_make_off", 32'(kb.note_off), 32'h0);
    check_eq("arst_make_act", 32'(kb.voice_active), 32'h1);
    do_reset();

    // Extended sequences, Space / Enter pulses
    send(8'hE0);
    send(8'h1C);
    check_eq("ext_on", 32'(kb.note_on), 32'h0);
    check_eq("ext_active", 32'(kb.voice_active), 32'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    check_eq("extbrk_off", 32'(kb.note_off), 32'h0);
    check_eq("extbrk_active", 32'(kb.voice_active), 32'h0);
    send(8'h29);
    check_eq("space_low", 32'(kb.load_n), 32'h0);
    idle();
    check_eq("space_high", 32'(kb.load_n), 32'h1);
    send(8'h5A);
    check_eq("enter_hi", 32'(kb.playback), 32'h1);
    idle();
    check_eq("enter_lo", 32'(kb.playback), 32'h0);
    send(8'hF0);
    send(8'h5A);
    check_eq("enter_brk", 32'(kb.playback), 32'h0);
    check_eq("enter_brk_ld", 32'(kb.load_n), 32'h1);
    send(8'h1C);
    check_eq("post_ext_on", 32'(kb.note_on), 32'h1);
    // A byte without code_valid is ignored
    @(negedge clk);
    kb.code = 8'h15;
    @(negedge clk);
    check_eq("novalid_active", 32'(kb.voice_active), 32'h1);
    do_reset();

    // Octave keys and optional stepping
    send(8'h16);
    check_eq("oct0", 32'(kb.octave), 32'h0);
    send(8'h1A);
    check_eq("oct_dn_sat", 32'(kb.octave), 32'h0);
    send(8'h25);
    check_eq("oct3", 32'(kb.octave), 32'h3);
    send(8'h22);
    send(8'h22);
    check_eq("oct_up_sat", 32'(kb.octave), 32'h3);
    send(8'h26);
    send(8'h1A);
`ifdef KEYBOARD_OCTAVE_STEP_EN
    check_eq("oct_step_dn", 32'(kb.octave), 32'h1);
`else
    check_eq("oct_step_dn", 32'(kb.octave), 32'h2);
`endif
    send(8'h1E);
    send(8'h22);
`ifdef KEYBOARD_OCTAVE_STEP_EN
    check_eq("oct_step_up", 32'(kb.octave), 32'h2);
`else
    check_eq("oct_step_up", 32'(kb.octave), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_voice_tracker.md
Name: keyboard_voice_tracker

Overview:
- Clocked successor to the combinational keyboard-code converter.
- Consumes raw PS/2 scan bytes from the keyboard receiver and parses make, break (F0) and extended (E0) sequences.
- Tracks up to NUM_VOICES simultaneously held note keys in voice slots and drives them to the tone generators.
- Also owns the octave register and the load/playback control pulses for the recorder.

Parameters:
- NUM_VOICES, 4, number of note slots (polyphony), 1..8.
- NOTE_W, 4, width of a note code; 1..12 = A..G#, 0 = none.
- OCT_W, 2, width of the octave value.
- DEFAULT_OCTAVE, 1, octave loaded at reset.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- code  in  8  scan byte from PS/2 receiver.
- code_valid  in  1  one-cycle strobe; code is valid.
- voice_note  out  NUM_VOICES*NOTE_W  slot i at bits [i*NOTE_W +: NOTE_W].
- voice_octave  out  NUM_VOICES*OCT_W  octave captured when slot i was filled.
- voice_active  out  NUM_VOICES  slot occupied mask.
- octave  out  OCT_W  current octave.
- note_on  out  1  one-cycle pulse: a slot was filled.
- note_off  out  1  one-cycle pulse: a slot was freed.
- load_n  out  1  active-low, one-cycle pulse on Space make.
- playback  out  1  one-cycle pulse on Enter make.
- overflow  out  1  sticky: a note make was dropped because all slots were full.

Behaviour:
- Reset values: voice_note 0, voice_octave 0, voice_active 0, octave DEFAULT_OCTAVE, note_on 0, note_off 0, load_n 1, playback 0, overflow 0. Parser state is IDLE.
- All outputs are registered. Effects appear the cycle after the code_valid cycle that completes a sequence. Bytes without code_valid are ignored.
- Parser FSM:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is processed as a make.
  - BRK: the byte is processed as a break, then -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte is discarded, then -> IDLE.
  - EXT_BRK: byte discarded, then -> IDLE. Extended keys have no effect.
  - A repeated E0 or F0 while in BRK or EXT is treated as a data byte; no nesting.
- Note map: 1C=1, 15=2, 1B=3, 23=4, 24=5, 2B=6, 2D=7, 34=8, 33=9, 35=10, 3B=11, 3C=12.
- Other keys: 16/1E/26/25 = octave 0/1/2/3. 29 = Space. 5A = Enter.
- Note make:
  - If any active slot already holds that note (typematic repeat), no change and no pulse.
  - Otherwise fill the lowest-index free slot with {note, current octave}, set its active bit, and pulse note_on.
  - If no slot is free: no change, overflow <= 1.
- Note break:
  - The slot holding that note is cleared (note 0, octave 0, active 0) and note_off pulses. Match is on note only, regardless of the octave changing since press.
  - Break of an unheld note: no effect.
- Octave key make: octave <= value. Held voices keep their captured octave. Octave key break: no effect.
- Space make: load_n low for exactly one cycle. Enter make: playback high for one cycle. Typematic repeats re-pulse. Breaks: no effect.
- Unmapped make/break codes: ignored, FSM returns to IDLE.
- At most one sequence completes per cycle, so note_on and note_off are never high together.
- overflow clears only on reset.
- resetn low at any point, including mid-sequence after F0 or E0: everything returns to reset values asynchronously.

Optional Feature:
- Macro: KEYBOARD_OCTAVE_STEP_EN.
- When defined: make of 1A (Z) decrements octave and make of 22 (X) increments it. Both saturate at 0 and 2^OCT_W-1, with no wrap.
- When undefined: 1A and 22 are unmapped and ignored. Octave changes only via 16/1E/26/25.

Test Plan:
- Reset, then code 1C -> next cycle slot0 = {note 1, octave 1}, voice_active=0001, note_on pulse. Then F0,1C -> slot0 cleared, note_off pulse.
- 1C, 1C, 1C (typematic) -> only one note_on and one slot used. Then 26 then 23 -> slot1 = {note 4, octave 2}; slot0 still octave 1.
- With NUM_VOICES=4: makes 1C,15,1B,23 fill slots 0..3. Make 24 -> no note_on, overflow=1. F0,15 frees slot1. Make 24 -> slot1 = note 5.
- E0,1C then E0,F0,1C -> no output change. Then 29 -> load_n low exactly one cycle. Then 5A -> playback high one cycle. F0,5A -> nothing.
- Send F0 then assert resetn low -> all outputs at reset values. After release, 1C is treated as a make (slot0 filled, not a break).
- With KEYBOARD_OCTAVE_STEP_EN: 16 then 1A -> octave stays 0. 25, 22, 22 -> octave stays 3. Without the macro, 1A -> no change.
